// File: rtl/mdu_pkg.sv
// Shared opcode encoding, counter width and opcode predicates for the HI/LO multiply-divide unit.
package mdu_pkg;

   localparam int CNT_W = 4;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MADD  = 4'd5;
   localparam logic [3:0] MDU_MADDU = 4'd6;
   localparam logic [3:0] MDU_MSUB  = 4'd7;
   localparam logic [3:0] MDU_MSUBU = 4'd8;
   localparam logic [3:0] MDU_MTHI  = 4'd9;
   localparam logic [3:0] MDU_MTLO  = 4'd10;

   function automatic logic is_long_op(input logic [3:0] op);
      return (op >= MDU_MULT) && (op <= MDU_MSUBU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_result_calc.sv
// Combinational 64-bit {HI,LO} result for every long MDU op, plus a divide-by-zero flag.
module mdu_result_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_hi,
   input  logic [31:0] i_lo,
   output logic [63:0] o_result,
   output logic        o_div_zero
);

   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [63:0] w_hilo;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_div_s;
   logic [31:0] w_div_u;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q_s;
   logic [31:0] w_r_s;

   assign w_prod_s = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
   assign w_hilo   = {i_hi, i_lo};

   // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
   assign w_a_mag = i_a[31] ? (32'd0 - i_a) : i_a;
   assign w_b_mag = i_b[31] ? (32'd0 - i_b) : i_b;
   assign w_div_s = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
   assign w_div_u = (i_b == 32'd0) ? 32'd1 : i_b;
   assign w_q_mag = w_a_mag / w_div_s;
   assign w_r_mag = w_a_mag % w_div_s;
   assign w_q_s   = (i_a[31] ^ i_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_r_s   = i_a[31] ? (32'd0 - w_r_mag) : w_r_mag;

   assign o_div_zero = is_div_op(i_op) && (i_b == 32'd0);

   always_comb begin
      o_result = w_hilo;
      case (i_op)
         MDU_MULT:  o_result = w_prod_s;
         MDU_MULTU: o_result = w_prod_u;
         MDU_DIV:   o_result = {w_r_s, w_q_s};
         MDU_DIVU:  o_result = {i_a % w_div_u, i_a / w_div_u};
         MDU_MADD:  o_result = w_hilo + w_prod_s;
         MDU_MADDU: o_result = w_hilo + w_prod_u;
         MDU_MSUB:  o_result = w_hilo - w_prod_s;
         MDU_MSUBU: o_result = w_hilo - w_prod_u;
         default:   o_result = w_hilo;
      endcase
   end

endmodule

// File: rtl/multiply_divide_unit.sv
// EX-stage HI/LO unit: MTHI/MTLO write in one cycle; long ops hold busy for MULT_CYCLES/DIV_CYCLES then commit.
// Starts presented while busy are dropped; the stall unit is expected to hold them in ID.
module multiply_divide_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mduStart,
   input  logic [3:0]  mduOperation,
   input  logic [31:0] mduInputA,
   input  logic [31:0] mduInputB,
   output logic        mduBusy,
   output logic [31:0] mduHi,
   output logic [31:0] mduLo
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   localparam logic [CNT_W-1:0] L_MULT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] L_DIV  = CNT_W'(DIV_CYCLES);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [63:0]      r_pend;
   logic             r_pend_dz;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;

   logic [63:0]      w_result;
   logic             w_div_zero;

   mdu_result_calc u_calc (
      .i_op       (mduOperation),
      .i_a        (mduInputA),
      .i_b        (mduInputB),
      .i_hi       (r_hi),
      .i_lo       (r_lo),
      .o_result   (w_result),
      .o_div_zero (w_div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_pend    <= '0;
         r_pend_dz <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mduStart) begin
                  if (mduOperation == MDU_MTHI) begin
                     r_hi <= mduInputA;
                  end else if (mduOperation == MDU_MTLO) begin
                     r_lo <= mduInputA;
                  end else if (is_long_op(mduOperation)) begin
                     r_pend    <= w_result;
                     r_pend_dz <= w_div_zero;
                     r_cnt     <= is_div_op(mduOperation) ? L_DIV : L_MULT;
                     r_state   <= S_BUSY;
                  end
               end
            end
            S_BUSY: begin
               // r_cnt == 1 marks edge T+L, the commit edge.
               if (r_cnt == CNT_W'(1)) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
                  if (!r_pend_dz) begin
                     r_hi <= r_pend[63:32];
                     r_lo <= r_pend[31:0];
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mduBusy = (r_state == S_BUSY);
   assign mduHi   = r_hi;
   assign mduLo   = r_lo;

endmodule
